// File: rtl/sys_defs.sv
// ----------------------------------------------------------------------------
// sys_defs: shared types and constants for the execute pipeline.
//   DATA       - 32-bit datapath word
//   REG_IDX    - 5-bit architectural register index
//   ALU_FUNC   - ALU opcode enumeration
//   OPA_SELECT - operand A source (RS1, PC, ZERO)
//   OPB_SELECT - operand B source (RS2, IMM, FOUR)
// ----------------------------------------------------------------------------
package sys_defs;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef logic [DATA_W-1:0] DATA;
  typedef logic [REG_W-1:0]  REG_IDX;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } ALU_FUNC;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } OPA_SELECT;

  typedef enum logic [1:0] {
    OPB_RS2  = 2'd0,
    OPB_IMM  = 2'd1,
    OPB_FOUR = 2'd2
  } OPB_SELECT;

  // Constant operand used for PC+4 style link computations.
  localparam DATA OPB_FOUR_VAL = 32'd4;

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu: purely combinational integer ALU, 32-bit wraparound arithmetic.
//   i_opa, i_opb  in  DATA      operands
//   i_func        in  ALU_FUNC  operation select
//   o_result      out DATA      result (0 for undefined opcodes)
// ----------------------------------------------------------------------------
module alu
  import sys_defs::*;
(
  input  DATA     i_opa,
  input  DATA     i_opb,
  input  ALU_FUNC i_func,
  output DATA     o_result
);

  logic signed [DATA_W-1:0] w_opa_s;
  logic signed [DATA_W-1:0] w_opb_s;
  logic        [4:0]        w_shamt;

  assign w_opa_s = i_opa;
  assign w_opb_s = i_opb;
  assign w_shamt = i_opb[4:0];

  always_comb begin
    o_result = '0;
    case (i_func)
      ALU_ADD:  o_result = i_opa + i_opb;
      ALU_SUB:  o_result = i_opa - i_opb;
      ALU_AND:  o_result = i_opa & i_opb;
      ALU_OR:   o_result = i_opa | i_opb;
      ALU_XOR:  o_result = i_opa ^ i_opb;
      ALU_SLL:  o_result = i_opa << w_shamt;
      ALU_SRL:  o_result = i_opa >> w_shamt;
      ALU_SRA:  o_result = DATA'(w_opa_s >>> w_shamt);
      ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, (w_opa_s < w_opb_s)};
      ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_opa < i_opb)};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage: two-deep execute pipeline (operand capture -> ALU -> result).
//   clock, reset_n (async, active-low), squash (sync flush of both stages)
//   in_valid/in_ready     upstream handshake; in_* carry the decoded op
//   in_opa_sel/in_opb_sel operand source selects, applied at capture
//   in_rs1_idx/in_rs2_idx source indices, only consulted for bypass
//   out_valid/out_ready   downstream handshake
//   out_result/out_dest_reg registered ALU result and its destination
// Optional feature macro: EX_BYPASS_EN forwards in-flight results into the
// RS1/RS2 operand values at capture (stage A has priority over stage B).
// ----------------------------------------------------------------------------
module ex_stage
  import sys_defs::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      squash,
  input  logic      in_valid,
  output logic      in_ready,
  input  OPA_SELECT in_opa_sel,
  input  OPB_SELECT in_opb_sel,
  input  DATA       in_rs1_value,
  input  DATA       in_rs2_value,
  input  DATA       in_pc,
  input  DATA       in_imm,
  input  REG_IDX    in_rs1_idx,
  input  REG_IDX    in_rs2_idx,
  input  ALU_FUNC   in_alu_func,
  input  REG_IDX    in_dest_reg,
  output logic      out_valid,
  input  logic      out_ready,
  output DATA       out_result,
  output REG_IDX    out_dest_reg
);

  DATA     r_opa_p0;
  DATA     r_opb_p0;
  ALU_FUNC r_func_p0;
  REG_IDX  r_dest_p0;
  logic    r_vld_p0;

  DATA     r_result_p1;
  REG_IDX  r_dest_p1;
  logic    r_vld_p1;

  logic    w_b_adv;
  logic    w_a_adv;
  logic    w_in_xfer;
  DATA     w_alu_result;
  DATA     w_rs1_val;
  DATA     w_rs2_val;
  DATA     w_opa;
  DATA     w_opb;

  assign w_b_adv   = !r_vld_p1 || out_ready;
  assign w_a_adv   = r_vld_p0 && w_b_adv;
  assign in_ready  = !r_vld_p0 || w_b_adv;
  assign w_in_xfer = in_valid && in_ready;

`ifdef EX_BYPASS_EN
  // Youngest producer wins: stage A's live ALU output, then stage B's result.
  function automatic DATA bypass(input REG_IDX idx, input DATA val,
                                 input logic vld_p0, input REG_IDX dest_p0,
                                 input DATA alu_res, input logic vld_p1,
                                 input REG_IDX dest_p1, input DATA res_p1);
    DATA r;
    r = val;
    if (idx != '0 && vld_p0 && idx == dest_p0)      r = alu_res;
    else if (idx != '0 && vld_p1 && idx == dest_p1) r = res_p1;
    return r;
  endfunction

  assign w_rs1_val = bypass(in_rs1_idx, in_rs1_value, r_vld_p0, r_dest_p0,
                            w_alu_result, r_vld_p1, r_dest_p1, r_result_p1);
  assign w_rs2_val = bypass(in_rs2_idx, in_rs2_value, r_vld_p0, r_dest_p0,
                            w_alu_result, r_vld_p1, r_dest_p1, r_result_p1);
`else
  // Source indices carry no meaning without forwarding.
  logic w_unused_idx;
  assign w_unused_idx = ^{in_rs1_idx, in_rs2_idx};
  assign w_rs1_val    = in_rs1_value;
  assign w_rs2_val    = in_rs2_value;
`endif

  always_comb begin
    w_opa = '0;
    case (in_opa_sel)
      OPA_RS1:  w_opa = w_rs1_val;
      OPA_PC:   w_opa = in_pc;
      OPA_ZERO: w_opa = '0;
      default:  w_opa = '0;
    endcase
  end

  always_comb begin
    w_opb = '0;
    case (in_opb_sel)
      OPB_RS2:  w_opb = w_rs2_val;
      OPB_IMM:  w_opb = in_imm;
      OPB_FOUR: w_opb = OPB_FOUR_VAL;
      default:  w_opb = '0;
    endcase
  end

  // ---- stage A: operand capture -------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opa_p0  <= '0;
      r_opb_p0  <= '0;
      r_func_p0 <= ALU_ADD;
      r_dest_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else if (squash) begin
      r_vld_p0  <= 1'b0;
    end else if (w_in_xfer) begin
      r_opa_p0  <= w_opa;
      r_opb_p0  <= w_opb;
      r_func_p0 <= in_alu_func;
      r_dest_p0 <= in_dest_reg;
      r_vld_p0  <= 1'b1;
    end else if (w_a_adv) begin
      r_vld_p0  <= 1'b0;
    end
  end

  alu u_alu (
    .i_opa    (r_opa_p0),
    .i_opb    (r_opb_p0),
    .i_func   (r_func_p0),
    .o_result (w_alu_result)
  );

  // ---- stage B: registered result -----------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result_p1 <= '0;
      r_dest_p1   <= '0;
      r_vld_p1    <= 1'b0;
    end else if (squash) begin
      r_vld_p1    <= 1'b0;
    end else if (w_a_adv) begin
      r_result_p1 <= w_alu_result;
      r_dest_p1   <= r_dest_p0;
      r_vld_p1    <= 1'b1;
    end else if (w_b_adv) begin
      r_vld_p1    <= 1'b0;
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_result   = r_result_p1;
  assign out_dest_reg = r_dest_p1;

endmodule

// File: doc/ex_stage.md
# ex_stage

Two-deep execute pipeline between issue and writeback: it accepts one decoded integer operation per cycle over a valid/ready handshake and selects operands from register values, PC, or immediate. It drives the combinational `alu`, registers the result, and presents it downstream over a second valid/ready handshake. Full back-pressure and a synchronous squash are supported, so issue can stall or flush it.

## Interface
Parameters:
- none. Widths come from `sys_defs`: DATA is 32 bits, ALU_FUNC is the ALU opcode enum, REG_IDX is 5 bits.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `squash`  in  1  synchronous flush of both stages.
- `in_valid`  in  1  upstream holds a valid operation.
- `in_ready`  out  1  stage can accept this cycle.
- `in_opa_sel`  in  OPA_SELECT  operand A source: OPA_RS1, OPA_PC, OPA_ZERO.
- `in_opb_sel`  in  OPB_SELECT  operand B source: OPB_RS2, OPB_IMM, OPB_FOUR.
- `in_rs1_value`, `in_rs2_value`, `in_pc`, `in_imm`  in  DATA  candidate operand values.
- `in_rs1_idx`, `in_rs2_idx`  in  REG_IDX  source indices; used only for bypass.
- `in_alu_func`  in  ALU_FUNC  operation.
- `in_dest_reg`  in  REG_IDX  destination register; 0 means no write.
- `out_valid`  out  1  result held for writeback.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  DATA  registered ALU result.
- `out_dest_reg`  out  REG_IDX  destination of `out_result`.

## Operation
- Stage A register holds the latched operands, `alu_func`, dest and `a_valid`. The `alu` instance reads stage A combinationally.
- Stage B register holds the result, dest and `b_valid`, and drives the out_* ports directly.
- Operand mux is applied at capture:
  - OPA_RS1 selects rs1_value, OPA_PC selects pc, OPA_ZERO selects 0.
  - OPB_RS2 selects rs2_value, OPB_IMM selects imm, OPB_FOUR selects 32'd4.
  - Undefined select encodings capture 0.
- Advance rules:
  - `b_adv = !b_valid || out_ready`.
  - `a_adv = a_valid && b_adv`.
  - `in_ready = !a_valid || b_adv`.
- Transfers:
  - Input transfer when `in_valid && in_ready`: stage A loads.
  - When `a_adv` is true: stage B loads the ALU result and dest.
  - When `b_adv && !a_adv`: `b_valid` clears.
- A simultaneous A→B move and new capture is the normal full-throughput case: one operation per cycle.
- Back-pressure:
  - With `out_ready` low and both stages full, `in_ready` is low.
  - Stage B holds `out_result`, `out_dest_reg` and `out_valid` stable until accepted.
- `squash`:
  - On the next edge, `a_valid` and `b_valid` clear, and any input offered that cycle is dropped.
  - Squash overrides every transfer. `in_ready` is still computed normally during squash.
- Reset (`reset_n` low, asynchronous) and the values it forces:
  - `a_valid`, `b_valid` and `out_valid` go to 0.
  - `out_result` and all data registers go to 0.
  - `out_dest_reg` goes to 0.
  - `in_ready` reads 1 once reset is released.
  - Reset mid-operation discards all in-flight work.

## Timing
- Latency: input accepted at edge k gives `out_valid` high after edge k+1. It is a 2-edge register-to-register path.
- Throughput: 1 operation per cycle while `out_ready` stays high.
- `in_ready` depends combinationally on `out_ready`, with no registered skid.
- The ALU sits between the two registers, which is the critical path. With bypass compiled in, it is ALU followed by the operand mux.
- Arithmetic is 32-bit wraparound, as defined by `alu`.

## Configuration
- `EX_BYPASS_EN`.
- When defined, RS1/RS2 operand values are bypassed at capture:
  - If the source idx ≠ 0 and matches the stage A dest with `a_valid`, the combinational ALU result is used.
  - Otherwise, if it matches the stage B dest with `b_valid`, `out_result` is used.
  - Otherwise the input value is used.
  - Stage A has priority over stage B.
- When undefined, the idx inputs are ignored and the input values are used unchanged.

## Structure
- `sys_defs` holds DATA, REG_IDX, ALU_FUNC, OPA_SELECT and OPB_SELECT, plus the constant for OPB_FOUR (32'd4).
- One sub-module: `alu`, instantiated once with no changes.
- The operand muxes, bypass and pipeline registers live inline in `ex_stage`.

## Test plan
- Reset release, then ADD with rs1=5, rs2=7 → `out_valid` after 2 edges with `out_result`=12 and the given dest. All outputs are 0 during reset.
- Back-to-back stream with `out_ready` high: SUB 3-5, then OPA_PC/OPB_FOUR with pc=0x100 → results 0xFFFFFFFE, then 0x104, on consecutive cycles.
- Hold `out_ready` low for 4 cycles with 3 ops offered → `in_ready` drops after 2 accepts and `out_result` stays stable. On release, all 3 drain in order and none are lost.
- Assert `squash` with both stages full → next cycle `out_valid`=0 and the offered input is not observed downstream.
- `EX_BYPASS_EN`: ADD x1=1+2, then ADD x2 = x1(stale 0)+10 back-to-back → second result 13. A repeat with dest x0 yields 10 (no bypass).
- Assert `reset_n` low mid-stream, asynchronously between edges → `out_valid` falls immediately and nothing is emitted afterwards.
